// File: rtl/ula_core.sv
// ula_core: registered two's-complement ALU (add, sub, AND, OR, XNOR, NOT A, pass A, NOT B).
// One-cycle latency, new result captured on every rising clk edge, async active-low reset.
// Optional status flags Z/N/C are built when the macro ULA_STATUS_EN is defined.
module ula_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       func,
  output logic [WIDTH-1:0] R,
  output logic             pinV
`ifdef ULA_STATUS_EN
  ,
  output logic             Z,
  output logic             N,
  output logic             C
`endif
);

  localparam logic [2:0] FN_ADD  = 3'b000;
  localparam logic [2:0] FN_SUB  = 3'b001;
  localparam logic [2:0] FN_AND  = 3'b010;
  localparam logic [2:0] FN_OR   = 3'b011;
  localparam logic [2:0] FN_XNOR = 3'b100;
  localparam logic [2:0] FN_NOTA = 3'b101;
  localparam logic [2:0] FN_PASS = 3'b110;
  localparam logic [2:0] FN_NOTB = 3'b111;

  // Signed overflow of a + b_op: equal operand signs but a differing result sign.
  // For subtraction b_op is ~B, so this reduces to "signs of A and B differ and the
  // result sign differs from A".
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    add_ovf = (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic                    is_sub;
  logic [WIDTH-1:0]        b_op;
  logic [WIDTH:0]          sum_ext;
  logic signed [WIDTH-1:0] r_d;
  logic                    pinv_d;
  logic [WIDTH-1:0]        r_q;
  logic                    pinv_q;
`ifdef ULA_STATUS_EN
  logic                    z_d, n_d, c_d;
  logic                    z_q, n_q, c_q;
`endif

  // Shared adder: subtraction is A + ~B + 1, carry-out kept one bit above the sum.
  always_comb begin
    is_sub  = (func == FN_SUB);
    b_op    = is_sub ? ~B : B;
    sum_ext = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
  end

  // Result/flag selection; logic ops never raise overflow and ignore the unused operand.
  always_comb begin
    r_d    = '0;
    pinv_d = 1'b0;
    unique case (func)
      FN_ADD, FN_SUB: begin
        r_d    = sum_ext[WIDTH-1:0];
        pinv_d = add_ovf(A[WIDTH-1], b_op[WIDTH-1], sum_ext[WIDTH-1]);
      end
      FN_AND:  r_d = A & B;
      FN_OR:   r_d = A | B;
      FN_XNOR: r_d = ~(A ^ B);
      FN_NOTA: r_d = ~A;
      FN_PASS: r_d = A;
      FN_NOTB: r_d = ~B;
      default: r_d = '0;
    endcase
  end

`ifdef ULA_STATUS_EN
  // Status flags derived from the selected result; C is carry-out (sub: 1 = no borrow).
  always_comb begin
    z_d = (r_d == '0);
    n_d = r_d[WIDTH-1];
    c_d = 1'b0;
    if (func == FN_ADD || func == FN_SUB) c_d = sum_ext[WIDTH];
  end
`endif

  // Output register stage; reset clears result and flags asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      pinv_q <= 1'b0;
`ifdef ULA_STATUS_EN
      z_q    <= 1'b1;
      n_q    <= 1'b0;
      c_q    <= 1'b0;
`endif
    end else begin
      r_q    <= r_d;
      pinv_q <= pinv_d;
`ifdef ULA_STATUS_EN
      z_q    <= z_d;
      n_q    <= n_d;
      c_q    <= c_d;
`endif
    end
  end

  assign R    = r_q;
  assign pinV = pinv_q;
`ifdef ULA_STATUS_EN
  assign Z    = z_q;
  assign N    = n_q;
  assign C    = c_q;
`endif

endmodule

// File: tb/tb_ula_core.sv
// tb_ula_core: scoreboard bench for ula_core (expected results queued at drive time,
// popped when the registered result appears one edge later). Z/N/C checked under ULA_STATUS_EN.
module tb_ula_core;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [2:0]    func = '0;
  logic [W-1:0]  R;
  logic          pinV;
`ifdef ULA_STATUS_EN
  logic          Z, N, C;
`endif

  ula_core #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .func (func),
    .R    (R),
    .pinV (pinV)
`ifdef ULA_STATUS_EN
    ,
    .Z    (Z),
    .N    (N),
    .C    (C)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic         v;
    logic         z;
    logic         n;
    logic         c;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Single comparison point: counts every comparison and reports mismatches.
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference model using wide signed arithmetic for overflow detection.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
    exp_t   e;
    longint sa, sb, s;
    logic [W:0] u;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'd0: begin
        s   = sa + sb;
        e.r = s[W-1:0];
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        u   = {1'b0, a} + {1'b0, b};
        e.c = u[W];
      end
      3'd1: begin
        s   = sa - sb;
        e.r = s[W-1:0];
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.c = (a >= b);
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = ~(a ^ b);
      3'd5: e.r = ~a;
      3'd6: e.r = a;
      default: e.r = ~b;
    endcase
    e.z = (e.r == '0);
    e.n = e.r[W-1];
    return e;
  endfunction

  // Drive one op between edges, queue its expectation, check it after the capturing edge.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f,
                       input string tag);
    exp_t e;
    @(negedge clk);
    A = a; B = b; func = f;
    exp_q.push_back(model(a, b, f));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, "_sbempty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_R"}, 64'(R), 64'(e.r));
      check_val({tag, "_V"}, 64'(pinV), 64'(e.v));
`ifdef ULA_STATUS_EN
      check_val({tag, "_Z"}, 64'(Z), 64'(e.z));
      check_val({tag, "_N"}, 64'(N), 64'(e.n));
      check_val({tag, "_C"}, 64'(C), 64'(e.c));
`endif
    end
  endtask

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    void'($urandom(32'd20240611));

    // Reset asserted before any clock edge must clear outputs immediately.
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_R", 64'(R), 64'd0);
    check_val("rst_V", 64'(pinV), 64'd0);
`ifdef ULA_STATUS_EN
    check_val("rst_Z", 64'(Z), 64'd1);
    check_val("rst_C", 64'(C), 64'd0);
`endif
    A = 32'd9; B = 32'd9; func = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_hold_R", 64'(R), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(32'd5, 32'd3, 3'd0, "first_add");
    check_val("first_add_8", 64'(R), 64'd8);

    // Adder corners.
    apply(32'h0, 32'h0, 3'd0, "add_0_0");
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, "add_m1_m1");
    check_val("add_m1_m1_lit", 64'(R), 64'(32'hFFFF_FFFE));
    apply(32'h7FFF_FFFF, 32'h1, 3'd0, "add_ovf");
    check_val("add_ovf_V_lit", 64'(pinV), 64'd1);
    apply(32'h8000_0000, 32'h8000_0000, 3'd0, "add_negovf");
    apply(32'h0, 32'h0, 3'd1, "sub_0_0");
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, "sub_m1_m1");
    apply(32'h8000_0000, 32'h1, 3'd1, "sub_ovf");
    check_val("sub_ovf_R_lit", 64'(R), 64'(32'h7FFF_FFFF));
    apply(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'd1, "sub_posovf");
    apply(32'd3, 32'd7, 3'd1, "sub_borrow");
    apply(32'd5, 32'd5, 3'd1, "sub_5_5");

    // Logic ops with fixed patterns.
    apply(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd2, "and");
    check_val("and_lit", 64'(R), 64'(32'hF000_F000));
    apply(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd3, "or");
    check_val("or_lit", 64'(R), 64'(32'hFFF0_FFF0));
    apply(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, "xnor");
    check_val("xnor_lit", 64'(R), 64'(32'hF00F_F00F));
    apply(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5, "nota");
    check_val("nota_lit", 64'(R), 64'(32'h0F0F_0F0F));
    apply(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd6, "passa");
    check_val("passa_lit", 64'(R), 64'(32'hF0F0_F0F0));
    apply(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7, "notb");
    check_val("notb_lit", 64'(R), 64'(32'h00FF_00FF));

    // Seeded random, one op per cycle, 12 per function.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 12; i++) begin
        ra = $urandom;
        rb = $urandom;
        if (i == 0) begin ra = 32'h7FFF_0000 | ra[15:0]; rb = 32'h7FFF_0000 | rb[15:0]; end
        apply(ra, rb, 3'(f), $sformatf("rnd_f%0d_%0d", f, i));
      end
    end

    // Reset mid-stream, asserted between edges.
    for (int i = 0; i < 4; i++) apply($urandom, $urandom, 3'(i), "pre_rst");
    apply(32'h7FFF_FFFF, 32'h1, 3'd0, "pre_rst_ovf");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("mid_rst_R", 64'(R), 64'd0);
    check_val("mid_rst_V", 64'(pinV), 64'd0);
`ifdef ULA_STATUS_EN
    check_val("mid_rst_Z", 64'(Z), 64'd1);
`endif
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'd5, 32'd5, 3'd1, "post_rst_sub");
    for (int i = 0; i < 6; i++) apply($urandom, $urandom, 3'($urandom_range(7, 0)), "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
